// File: rtl/sym_pkg.sv
// +----------------------------------------------------------------------+
// | Module : sym_pkg                                                     |
// | Shared types and helpers for the constant-weight pattern generator.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package sym_pkg;

    localparam int N_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        if (k < 0 || k > n) return 0;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] x);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, x[i]};
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sym_pattern_gen_if.sv
// +----------------------------------------------------------------------+
// | Module : sym_pattern_gen_if                                          |
// | Valid/ready pattern stream from the generator to its sink.           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface sym_pattern_gen_if #(
    parameter int N = sym_pkg::N_DEFAULT
);
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

`default_nettype wire

// File: rtl/sym_next_comb.sv
// +----------------------------------------------------------------------+
// | Module : sym_next_comb                                               |
// | Gosper successor of a constant-weight word, plus last-word detect.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sym_next_comb #(
    parameter int N  = 9,
    parameter int KW = 4
) (
    input  wire logic [N-1:0]  x_i,
    input  wire logic [KW-1:0] k_i,
    output logic      [N-1:0]  nxt_o,
    output logic               nxt_last_o
);
    localparam int CW = $clog2(N);

    logic [N-1:0]  w_low;
    logic [N-1:0]  w_ripple;
    logic [N-1:0]  w_ones;
    logic [N-1:0]  w_last_pat;
    logic [CW-1:0] w_ctz;

    always_comb begin
        w_low    = x_i & (~x_i + N'(1));
        w_ripple = x_i + w_low;
        w_ones   = (w_ripple ^ x_i) >> 2;
        // Scanning downward lets the lowest set bit win the encoder.
        w_ctz    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_low[i]) w_ctz = CW'(i);
        end
        nxt_o = (w_ones >> w_ctz) | w_ripple;
        for (int i = 0; i < N; i++) begin
            w_last_pat[i] = (i >= N - int'(k_i));
        end
        nxt_last_o = (nxt_o == w_last_pat);
    end

endmodule

`default_nettype wire

// File: rtl/sym_pattern_gen.sv
// +----------------------------------------------------------------------+
// | Module : sym_pattern_gen                                             |
// | Streams every N-bit word of weight K in ascending order.             |
// | Option : SYM_PATTERN_CHECK_EN adds a popcount/ordering checker.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sym_pattern_gen
    import sym_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int KW    = 4,
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [KW-1:0]      k,
    input  wire logic               abort,
    sym_pattern_gen_if.master       out_if,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNT_W-1:0]        count
);
    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [N-1:0]     data_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic [N-1:0]     w_first;
    logic             w_first_last;
    logic [N-1:0]     w_nxt;
    logic             w_nxt_last;
    logic             w_hs;

    sym_next_comb #(.N(N), .KW(KW)) u_next (
        .x_i        (data_q),
        .k_i        (k_q),
        .nxt_o      (w_nxt),
        .nxt_last_o (w_nxt_last)
    );

    always_comb begin
        for (int i = 0; i < N; i++) w_first[i] = (i < int'(k));
        w_first_last = (int'(k) == 0) || (int'(k) == N);
        w_hs         = valid_q && out_if.out_ready;
    end

`ifdef SYM_PATTERN_CHECK_EN
    logic [N-1:0] prev_q;
    logic         have_prev_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef SYM_PATTERN_CHECK_EN
            prev_q      <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        if (int'(k) <= N) begin
                            k_q     <= k;
                            data_q  <= w_first;
                            last_q  <= w_first_last;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= RUN;
`ifdef SYM_PATTERN_CHECK_EN
                            have_prev_q <= 1'b0;
`endif
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        count_q <= count_q + CNT_W'(1);
`ifdef SYM_PATTERN_CHECK_EN
                        prev_q      <= data_q;
                        have_prev_q <= 1'b1;
                        if ((popcount(32'(data_q)) != 6'(k_q)) ||
                            (have_prev_q && (data_q <= prev_q))) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                    // Abort takes the state even when a handshake lands in the same cycle.
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (w_hs) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            data_q <= w_nxt;
                            last_q <= w_nxt_last;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign count            = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sym_pattern_gen.sv
// +----------------------------------------------------------------------+
// | Module : tb_sym_pattern_gen                                          |
// | Directed + randomized bench for the constant-weight pattern stream.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sym_pattern_gen;
    import sym_pkg::*;

    localparam int N     = 9;
    localparam int KW    = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [KW-1:0]    k = '0;
    logic             abort = 1'b0;
    logic             busy, done, err;
    logic [CNT_W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    sym_pattern_gen_if #(.N(N)) bus ();

    sym_pattern_gen #(.N(N), .KW(KW), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .k      (k),
        .abort  (abort),
        .out_if (bus.master),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_done"},  32'(done),          32'd0);
        chk({tag, "_err"},   32'(err),           32'd0);
        chk({tag, "_count"}, 32'(count),         32'd0);
    endtask

    // mode 0: ready always high, 1: random ready, 2: five-cycle stall on word index 2
    task automatic do_seq(input int kk, input int mode, input int abort_after);
        logic [N-1:0] expq[$];
        logic [N-1:0] held;
        logic         held_v;
        logic         hs;
        logic         aborting;
        int           idx, cyc, stall;
        logic [31:0]  v32;

        expq = {};
        for (int v = 0; v < (1 << N); v++) begin
            v32 = 32'(v);
            if ($countones(v32) == kk) expq.push_back(v32[N-1:0]);
        end

        bus.out_ready = 1'b0;
        start = 1'b1;
        k     = KW'(kk);
        step();
        start = 1'b0;

        if (kk > N) begin
            chk("bad_k_valid", 32'(bus.out_valid), 32'd0);
            chk("bad_k_err",   32'(err),           32'd1);
            chk("bad_k_done",  32'(done),          32'd1);
            chk("bad_k_count", 32'(count),         32'd0);
            for (int i = 0; i < 4; i++) begin
                step();
                chk("bad_k_novalid", 32'(bus.out_valid), 32'd0);
                chk("bad_k_nodone",  32'(done),          32'd0);
                chk("bad_k_sticky",  32'(err),           32'd1);
            end
            return;
        end

        chk("first_latency", 32'(bus.out_valid), 32'd1);
        chk("err_cleared",   32'(err),           32'd0);
        idx = 0; cyc = 0; stall = 0; held_v = 1'b0; aborting = 1'b0; held = '0;
        while (idx < expq.size() && cyc < 2000) begin
            chk("run_valid", 32'(bus.out_valid), 32'd1);
            chk("run_busy",  32'(busy),          32'd1);
            if (held_v) chk("held_data", 32'(bus.out_data), 32'(held));
            case (mode)
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (idx == 2 && stall < 5) begin
                        bus.out_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
            if (abort_after >= 0 && idx == abort_after - 1) begin
                abort = 1'b1;
                bus.out_ready = 1'b1;
                aborting = 1'b1;
            end
            if (mode == 0 && idx == 20) begin
                start = 1'b1;
                k     = 4'd1;
            end
            hs     = bus.out_valid && bus.out_ready;
            held   = bus.out_data;
            held_v = !hs;
            if (hs) begin
                chk("word_data", 32'(bus.out_data), 32'(expq[idx]));
                chk("word_last", 32'(bus.out_last), 32'(idx == expq.size() - 1));
            end
            step();
            start = 1'b0;
            abort = 1'b0;
            if (hs) idx++;
            cyc++;
            if (aborting) break;
        end
        bus.out_ready = 1'b0;
        chk("cycle_budget", 32'(cyc < 2000), 32'd1);

        if (aborting) begin
            chk("abort_valid", 32'(bus.out_valid), 32'd0);
            chk("abort_done",  32'(done),          32'd0);
            chk("abort_busy",  32'(busy),          32'd0);
            chk("abort_count", 32'(count),         32'(abort_after));
            step();
            chk("abort_nodone", 32'(done),  32'd0);
            chk("abort_hold",   32'(count), 32'(abort_after));
        end else begin
            chk("end_valid", 32'(bus.out_valid), 32'd0);
            chk("end_done",  32'(done),          32'd1);
            chk("end_busy",  32'(busy),          32'd0);
            chk("end_count", 32'(count),         32'(binom(N, kk)));
            chk("end_err",   32'(err),           32'd0);
            step();
            chk("done_pulse", 32'(done),  32'd0);
            chk("count_hold", 32'(count), 32'(expq.size()));
        end
        step();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        chk_idle_outputs("reset");
        step();
        rst = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle_outputs("idle_abort");

        do_seq(3, 0, -1);
        do_seq(0, 0, -1);
        do_seq(9, 0, -1);
        do_seq(10, 0, -1);
        do_seq(1, 0, -1);
        do_seq(4, 2, -1);
        do_seq(2, 1, -1);
        do_seq(5, 0, 10);
        for (int r = 0; r < 3; r++) do_seq(int'($urandom_range(0, 9)), 1, -1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        k     = 4'd6;
        step();
        start = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk_idle_outputs("post_rst");
        do_seq(8, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
